// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler
// Front end for the DDR3 controller state machine. It debounces the board
// write/read buttons, captures the switch byte when a write press is
// accepted, and generates periodic refresh requests with a bounded
// postponement count. It arbitrates refresh > write > read and holds exactly
// one request level until the controller acknowledges it.
//
// Ports:
//   CLK, RESET      system clock, synchronous active-high reset
//   btn_write       raw asynchronous write button
//   btn_read        raw asynchronous read button
//   switch[7:0]     write data source, captured on an accepted write press
//   cmd_ack         one-cycle accept pulse from the controller
//   REF/WRITE/READ  registered request levels, at most one high
//   Data_Write[7:0] byte captured at the accepted write press
//   ref_pending[3:0] queued refresh count
//   ref_overflow    sticky, a refresh tick was lost at saturation
//   ack_timeout     sticky, a request waited ACK_TIMEOUT cycles for an ack
//   busy            high while a request is being presented

// Synchronizer plus level debouncer for one button. The debounced level only
// follows the synchronized input after CYCLES consecutive differing cycles.
// rise is high for the one cycle after the debounced level goes 0 to 1.
module dram_btn_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // The counter only runs while the synchronized input disagrees with the
  // debounced level; any agreeing cycle restarts the qualification window.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 != level) begin
        if (cnt == CW'(CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

module dram_cmd_scheduler #(
  parameter int REF_INTERVAL    = 6400000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_PENDING     = 8,
  parameter int ACK_TIMEOUT     = 4096
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       btn_write,
  input  logic       btn_read,
  input  logic [7:0] switch,
  input  logic       cmd_ack,
  output logic       REF,
  output logic       WRITE,
  output logic       READ,
  output logic [7:0] Data_Write,
  output logic [3:0] ref_pending,
  output logic       ref_overflow,
  output logic       ack_timeout,
  output logic       busy
);

  localparam int RW = $clog2(REF_INTERVAL + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE_REF, ISSUE_WR, ISSUE_RD} state_t;

  state_t        state;
  state_t        state_next;
  logic          wr_rise;
  logic          rd_rise;
  logic          wr_pend;
  logic          rd_pend;
  logic [RW-1:0] ref_cnt;
  logic          ref_tick;
  logic [AW-1:0] wait_cnt;
  logic          wait_expired;
  logic          ack_ref;
  logic          ack_wr;
  logic          ack_rd;
  logic          timeout_hit;
  logic          wr_set;
  logic          rd_set;

  dram_btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_write (
    .clk   (CLK),
    .reset (RESET),
    .raw   (btn_write),
    .rise  (wr_rise)
  );

  dram_btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_read (
    .clk   (CLK),
    .reset (RESET),
    .raw   (btn_read),
    .rise  (rd_rise)
  );

  assign ref_tick     = (ref_cnt == RW'(REF_INTERVAL - 1));
  assign wait_expired = (wait_cnt == AW'(ACK_TIMEOUT - 1));

  // A new press is accepted when nothing is pending, or when the old request
  // is being acknowledged in the same cycle, so the pend stays set.
  assign wr_set = wr_rise & (~wr_pend | ack_wr);
  assign rd_set = rd_rise & (~rd_pend | ack_rd);

  // Arbiter next state. An ack wins over a simultaneous timeout; a timeout
  // drops back to IDLE without clearing the request so it is retried.
  always_comb begin
    state_next  = state;
    ack_ref     = 1'b0;
    ack_wr      = 1'b0;
    ack_rd      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (ref_pending != 4'd0)
          state_next = ISSUE_REF;
        else if (wr_pend)
          state_next = ISSUE_WR;
        else if (rd_pend)
          state_next = ISSUE_RD;
      end
      ISSUE_REF: begin
        if (cmd_ack) begin
          ack_ref    = 1'b1;
          state_next = IDLE;
        end else if (wait_expired) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      ISSUE_WR: begin
        if (cmd_ack) begin
          ack_wr     = 1'b1;
          state_next = IDLE;
        end else if (wait_expired) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      ISSUE_RD: begin
        if (cmd_ack) begin
          ack_rd     = 1'b1;
          state_next = IDLE;
        end else if (wait_expired) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with request outputs decoded from the next state, so the
  // levels are registered and drop in the same edge that takes the ack.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      REF   <= 1'b0;
      WRITE <= 1'b0;
      READ  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      REF   <= (state_next == ISSUE_REF);
      WRITE <= (state_next == ISSUE_WR);
      READ  <= (state_next == ISSUE_RD);
      busy  <= (state_next != IDLE);
    end
  end

  // Wait counter is held at zero in IDLE and on the way out of an ISSUE
  // state, so every ISSUE entry starts a fresh timeout window.
  always_ff @(posedge CLK) begin
    if (RESET)
      wait_cnt <= '0;
    else if (state == IDLE || state_next == IDLE)
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Refresh interval timer and postponement count. A tick coinciding with a
  // refresh ack cancels out and never counts as an overflow.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ref_cnt      <= '0;
      ref_pending  <= 4'd0;
      ref_overflow <= 1'b0;
    end else begin
      ref_cnt <= ref_tick ? '0 : ref_cnt + 1'b1;
      case ({ref_tick, ack_ref})
        2'b10: begin
          if (ref_pending == 4'(MAX_PENDING))
            ref_overflow <= 1'b1;
          else
            ref_pending <= ref_pending + 1'b1;
        end
        2'b01:   ref_pending <= ref_pending - 1'b1;
        default: ref_pending <= ref_pending;
      endcase
    end
  end

  // Button request flags, write data capture and the sticky timeout flag.
  // Data_Write only moves when a write press is accepted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_pend     <= 1'b0;
      rd_pend     <= 1'b0;
      Data_Write  <= 8'h00;
      ack_timeout <= 1'b0;
    end else begin
      if (wr_set) begin
        wr_pend    <= 1'b1;
        Data_Write <= switch;
      end else if (ack_wr) begin
        wr_pend <= 1'b0;
      end
      if (rd_set)
        rd_pend <= 1'b1;
      else if (ack_rd)
        rd_pend <= 1'b0;
      if (timeout_hit)
        ack_timeout <= 1'b1;
    end
  end

endmodule
